dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port, byte-addressed, big-endian data memory between the processor's load/store path (CPU port) and a host/loader port. Grants one word access per cycle using round-robin. Supports a bounded host lock for back-to-back host bursts and returns read data with a registered valid strobe. Sits between the CPU datapath (`sum`/`datab`/`memwrite`/`memread`) and the data-memory array.

## Interface
Parameters:
- `ADDR_W`, 6, byte-address width (64-byte memory)
- `MAX_LOCK`, 4, maximum consecutive locked host grants while the CPU is waiting (≥1)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  CPU access request; held with stable fields until `cpu_gnt`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  byte address; bits [1:0] must be 0
- `cpu_wdata`  in  32  write word; [31:24] goes to the lowest address
- `cpu_gnt`  out  1  combinational grant, same cycle as the access
- `cpu_rvalid`  out  1  registered; read data valid for the CPU
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_gnt`, `host_rvalid`: same semantics for the host
- `host_lock`  in  1  requests burst lock, sampled with `host_req`
- `rdata`  out  32  shared read-data bus, `mem_rdata` passed through
- `misalign`  out  1  registered; pulses 1 cycle after a granted access with addr[1:0] ≠ 0
- `mem_en`, `mem_we`  out  1  memory strobe and write enable
- `mem_addr`  out  ADDR_W  granted address, word-aligned (addr[1:0] forced to 0)
- `mem_wdata`  out  32  granted write data
- `mem_rdata`  in  32  memory read word, valid one cycle after `mem_en` for a read

## Operation
- At most one grant per cycle. `mem_en = cpu_gnt | host_gnt`. Memory fields mux from the granted port, else zero.
- FSM states are `S_RR` and `S_LOCK`. Registers are `last` (CPU/HOST) and `lock_cnt` [clog2(MAX_LOCK+1)].
- S_RR:
  - Single requester is granted.
  - Both requesting: the port other than `last` is granted.
  - A host grant with `host_lock=1` moves to S_LOCK with `lock_cnt=1`.
  - Every grant updates `last`.
- S_LOCK:
  - If `host_req & host_lock` and (`lock_cnt<MAX_LOCK` or `!cpu_req`), grant host. `lock_cnt` increments, saturating at MAX_LOCK.
  - Otherwise, if `cpu_req`, grant CPU, go to S_RR, set `lock_cnt=0` and `last=CPU`.
  - Otherwise, if `host_req` without lock, grant host and go to S_RR.
  - Otherwise (no request), go to S_RR with `last=HOST`.
- Reads: `cpu_rvalid`/`host_rvalid` are set the cycle after a granted read by that port. `rdata` carries `mem_rdata` during that cycle.
- Misaligned access: the access is still performed at the aligned address and `misalign` pulses.
- Reset values: state S_RR, `last=HOST` (CPU wins the first tie), `lock_cnt=0`. `cpu_rvalid`, `host_rvalid` and `misalign` are 0. Grants follow their inputs combinationally.

## Timing
- Grant latency is 0 cycles. A write commits at the rising edge ending the grant cycle.
- Read latency is 1 cycle (grant at N → rvalid and rdata at N+1). Back-to-back reads give one rvalid per cycle.
- A read at N+1 to an address written at N returns the new data.
- Worst-case CPU wait is MAX_LOCK cycles under lock, 1 cycle otherwise.
- `reset` asserted mid-lock: the next cycle is S_RR with `lock_cnt=0`. Any rvalid pending from a read before reset is suppressed (0).
- A request dropped before grant is a protocol violation; no state is retained for it.

## Configuration
- `DMEM_ARB_CPU_PRIO_EN` defined:
  - CPU has fixed absolute priority and the host is granted only when `cpu_req=0`.
  - `host_lock` is ignored, S_LOCK is unreachable and `lock_cnt` stays 0.
- Not defined: round-robin plus bounded lock as described above.

## Test plan
- Reset, then both ports read simultaneously (CPU addr 0x08, host addr 0x10):
  - Cycle 0 grants the CPU; cycle 1 grants the host.
  - `cpu_rvalid` at cycle 1 and `host_rvalid` at cycle 2 with the preloaded words.
- CPU writes 0xDEADBEEF to 0x04, then reads 0x04:
  - Bytes 4..7 become DE, AD, BE, EF.
  - Read returns 0xDEADBEEF one cycle after its grant.
- Host holds `host_req=host_lock=1` for 10 cycles while the CPU requests continuously (MAX_LOCK=4):
  - Grants are H,H,H,H,C then the cycle repeats.
  - `lock_cnt` returns to 0 after each CPU grant.
- Host lock with no CPU request for 8 cycles: 8 consecutive host grants, `lock_cnt` saturates at 4.
- Host read of addr 0x0A:
  - `mem_addr=0x08`.
  - `misalign=1` and `host_rvalid=1` one cycle later.
- `reset` asserted during S_LOCK with a read outstanding: the next cycle has both rvalids at 0 and a tie grants the CPU. Rerun with `DMEM_ARB_CPU_PRIO_EN`: the host is never granted while `cpu_req=1`.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port, byte-addressed, big-endian data memory between the
// CPU load/store path and a host/loader port. One word access is granted per
// cycle. Simultaneous requests are resolved round-robin. The host may lock the
// memory for a bounded burst. Read data returns one cycle after the grant,
// with a registered per-port valid strobe.
//
// Optional feature macro: DMEM_ARB_CPU_PRIO_EN
//   defined     -> CPU has fixed absolute priority, host_lock ignored
//   not defined -> round-robin with bounded host lock
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU access request (held until cpu_gnt)
//   cpu_gnt                    combinational CPU grant
//   cpu_rvalid                 registered CPU read-data valid
//   host_req/we/addr/wdata     host access request (held until host_gnt)
//   host_lock                  host burst-lock request, sampled with host_req
//   host_gnt, host_rvalid      host grant / read-data valid
//   rdata                      shared read-data bus (mem_rdata passthrough)
//   misalign                   registered pulse after a granted access with
//                              addr[1:0] != 0
//   mem_en/we/addr/wdata       memory strobe, write enable, aligned address,
//                              write data
//   mem_rdata                  memory read word, one cycle after a read strobe
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  localparam logic S_RR      = 1'b0;
  localparam logic S_LOCK    = 1'b1;
  localparam logic LAST_CPU  = 1'b0;
  localparam logic LAST_HOST = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LOCK);

  logic             state_r;
  logic             state_nx_s;
  logic             last_r;
  logic             last_nx_s;
  logic [CNT_W-1:0] lock_cnt_r;
  logic [CNT_W-1:0] lock_cnt_nx_s;
  logic             cpu_gnt_s;
  logic             host_gnt_s;
  logic             cpu_rvalid_r;
  logic             host_rvalid_r;
  logic             misalign_r;

`ifdef DMEM_ARB_CPU_PRIO_EN
  // Fixed priority: CPU always wins, the lock machinery is parked.
  always_comb begin
    cpu_gnt_s     = cpu_req;
    host_gnt_s    = host_req & ~cpu_req;
    state_nx_s    = S_RR;
    lock_cnt_nx_s = CNT_ZERO;
    if (cpu_gnt_s) begin
      last_nx_s = LAST_CPU;
    end else if (host_gnt_s) begin
      last_nx_s = LAST_HOST;
    end else begin
      last_nx_s = last_r;
    end
  end
`else
  // Round-robin arbitration with bounded host burst lock.
  always_comb begin
    cpu_gnt_s     = 1'b0;
    host_gnt_s    = 1'b0;
    state_nx_s    = state_r;
    last_nx_s     = last_r;
    lock_cnt_nx_s = lock_cnt_r;
    case (state_r)
      S_RR: begin
        // On a tie the port that did not win last time is served.
        if (cpu_req && host_req) begin
          if (last_r == LAST_CPU) begin
            host_gnt_s = 1'b1;
          end else begin
            cpu_gnt_s = 1'b1;
          end
        end else if (cpu_req) begin
          cpu_gnt_s = 1'b1;
        end else if (host_req) begin
          host_gnt_s = 1'b1;
        end else begin
          cpu_gnt_s = 1'b0;
        end

        if (cpu_gnt_s) begin
          last_nx_s     = LAST_CPU;
          state_nx_s    = S_RR;
          lock_cnt_nx_s = CNT_ZERO;
        end else if (host_gnt_s && host_lock) begin
          last_nx_s     = LAST_HOST;
          state_nx_s    = S_LOCK;
          lock_cnt_nx_s = CNT_ONE;
        end else if (host_gnt_s) begin
          last_nx_s     = LAST_HOST;
          state_nx_s    = S_RR;
          lock_cnt_nx_s = CNT_ZERO;
        end else begin
          state_nx_s    = S_RR;
          lock_cnt_nx_s = CNT_ZERO;
        end
      end
      S_LOCK: begin
        // The lock only yields to a waiting CPU once the burst budget is spent.
        if (host_req && host_lock && ((lock_cnt_r < CNT_MAX) || !cpu_req)) begin
          host_gnt_s = 1'b1;
          last_nx_s  = LAST_HOST;
          state_nx_s = S_LOCK;
          if (lock_cnt_r < CNT_MAX) begin
            lock_cnt_nx_s = lock_cnt_r + CNT_ONE;
          end else begin
            lock_cnt_nx_s = CNT_MAX;
          end
        end else if (cpu_req) begin
          cpu_gnt_s     = 1'b1;
          last_nx_s     = LAST_CPU;
          state_nx_s    = S_RR;
          lock_cnt_nx_s = CNT_ZERO;
        end else if (host_req) begin
          host_gnt_s    = 1'b1;
          last_nx_s     = LAST_HOST;
          state_nx_s    = S_RR;
          lock_cnt_nx_s = CNT_ZERO;
        end else begin
          last_nx_s     = LAST_HOST;
          state_nx_s    = S_RR;
          lock_cnt_nx_s = CNT_ZERO;
        end
      end
      default: begin
        last_nx_s     = LAST_HOST;
        state_nx_s    = S_RR;
        lock_cnt_nx_s = CNT_ZERO;
      end
    endcase
  end
`endif

  // Arbitration state; after reset the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_RR;
      last_r     <= LAST_HOST;
      lock_cnt_r <= CNT_ZERO;
    end else begin
      state_r    <= state_nx_s;
      last_r     <= last_nx_s;
      lock_cnt_r <= lock_cnt_nx_s;
    end
  end

  // Read-valid and misalign strobes; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid_r  <= 1'b0;
      host_rvalid_r <= 1'b0;
      misalign_r    <= 1'b0;
    end else begin
      cpu_rvalid_r  <= cpu_gnt_s & ~cpu_we;
      host_rvalid_r <= host_gnt_s & ~host_we;
      misalign_r    <= (cpu_gnt_s & (|cpu_addr[1:0])) |
                       (host_gnt_s & (|host_addr[1:0]));
    end
  end

  // Memory-side mux from the granted port; address forced word-aligned.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = 32'h0000_0000;
    if (cpu_gnt_s) begin
      mem_we    = cpu_we;
      mem_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = cpu_wdata;
    end else if (host_gnt_s) begin
      mem_we    = host_we;
      mem_addr  = {host_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = host_wdata;
    end else begin
      mem_we    = 1'b0;
    end
  end

  assign mem_en      = cpu_gnt_s | host_gnt_s;
  assign cpu_gnt     = cpu_gnt_s;
  assign host_gnt    = host_gnt_s;
  assign cpu_rvalid  = cpu_rvalid_r;
  assign host_rvalid = host_rvalid_r;
  assign misalign    = misalign_r;
  assign rdata       = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. A byte-array memory model sits on the
// memory port. Read results are predicted from a separate reference copy of
// the memory, pushed to per-port queues when a read is granted, and popped
// and compared the cycle after.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W   = 6;
  localparam int MAX_LOCK = 4;
`ifdef DMEM_ARB_CPU_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic              host_lock;
  logic              host_gnt;
  logic              host_rvalid;
  logic [31:0]       rdata;
  logic              misalign;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [7:0]  mem     [0:63];
  logic [7:0]  ref_mem [0:63];
  logic [31:0] cpu_q[$];
  logic [31:0] host_q[$];
  int          n_cmp;
  int          n_err;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_lock  (host_lock),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .rdata      (rdata),
    .misalign   (misalign),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Big-endian single-port memory behind the arbiter.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]         <= mem_wdata[31:24];
        mem[mem_addr + 6'd1]  <= mem_wdata[23:16];
        mem[mem_addr + 6'd2]  <= mem_wdata[15:8];
        mem[mem_addr + 6'd3]  <= mem_wdata[7:0];
      end else begin
        mem_rdata <= {mem[mem_addr], mem[mem_addr + 6'd1],
                      mem[mem_addr + 6'd2], mem[mem_addr + 6'd3]};
      end
    end
  end

  function automatic logic [31:0] ref_word(input logic [5:0] a);
    logic [5:0] b;
    b = {a[5:2], 2'b00};
    return {ref_mem[b], ref_mem[b + 6'd1], ref_mem[b + 6'd2], ref_mem[b + 6'd3]};
  endfunction

  task automatic ref_write(input logic [5:0] a, input logic [31:0] d);
    logic [5:0] b;
    b = {a[5:2], 2'b00};
    ref_mem[b]        = d[31:24];
    ref_mem[b + 6'd1] = d[23:16];
    ref_mem[b + 6'd2] = d[15:8];
    ref_mem[b + 6'd3] = d[7:0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive requests, check grants, predict and check the
  // registered results after the edge.
  task automatic step(input logic cr, input logic cw, input logic [5:0] ca,
                      input logic [31:0] cd, input logic hr, input logic hw,
                      input logic [5:0] ha, input logic [31:0] hd, input logic hl,
                      input logic ec, input logic eh, input string tag);
    logic mis_n;
    logic rst_edge;
    cpu_req = cr;  cpu_we = cw;  cpu_addr = ca;  cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
    #1;
    chk({tag, "/cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, ec});
    chk({tag, "/host_gnt"}, {31'd0, host_gnt}, {31'd0, eh});
    chk({tag, "/mem_en"}, {31'd0, mem_en}, {31'd0, ec | eh});
    mis_n = 1'b0;
    if (ec) begin
      chk({tag, "/mem_addr"}, {26'd0, mem_addr}, {26'd0, ca[5:2], 2'b00});
      chk({tag, "/mem_we"}, {31'd0, mem_we}, {31'd0, cw});
      mis_n = (ca[1:0] != 2'b00);
      if (cw) ref_write(ca, cd);
      else    cpu_q.push_back(ref_word(ca));
    end else if (eh) begin
      chk({tag, "/mem_addr"}, {26'd0, mem_addr}, {26'd0, ha[5:2], 2'b00});
      chk({tag, "/mem_we"}, {31'd0, mem_we}, {31'd0, hw});
      mis_n = (ha[1:0] != 2'b00);
      if (hw) ref_write(ha, hd);
      else    host_q.push_back(ref_word(ha));
    end else begin
      mis_n = 1'b0;
    end
    rst_edge = reset;
    @(posedge clk);
    #1;
    if (rst_edge) begin
      cpu_q.delete();
      host_q.delete();
      mis_n = 1'b0;
    end
    chk({tag, "/cpu_rvalid"}, {31'd0, cpu_rvalid}, {31'd0, cpu_q.size() != 0});
    if (cpu_q.size() != 0) chk({tag, "/cpu_rdata"}, rdata, cpu_q.pop_front());
    chk({tag, "/host_rvalid"}, {31'd0, host_rvalid}, {31'd0, host_q.size() != 0});
    if (host_q.size() != 0) chk({tag, "/host_rdata"}, rdata, host_q.pop_front());
    chk({tag, "/misalign"}, {31'd0, misalign}, {31'd0, mis_n});
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 8'(8'hA0 + i);
      ref_mem[i] = 8'(8'hA0 + i);
    end
    mem_rdata = 32'h0;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 6'h00; cpu_wdata = 32'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 6'h00; host_wdata = 32'h0;
    host_lock = 1'b0;
    @(posedge clk);
    #1;

    // Reset: no grants, strobes low.
    idle("reset0");
    idle("reset1");
    reset = 1'b0;

    // Simultaneous reads: CPU wins the first tie, then host.
    step(1'b1, 1'b0, 6'h08, 32'h0, 1'b1, 1'b0, 6'h10, 32'h0, 1'b0, 1'b1, 1'b0, "tie_c");
    step(1'b0, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0, 6'h10, 32'h0, 1'b0, 1'b0, 1'b1, "tie_h");
    idle("tie_drain");

    // CPU write then read-after-write.
    step(1'b1, 1'b1, 6'h04, 32'hDEADBEEF, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0,
         1'b1, 1'b0, "wr");
    chk("byte4", {24'd0, mem[4]}, 32'h0000_00DE);
    chk("byte5", {24'd0, mem[5]}, 32'h0000_00AD);
    chk("byte6", {24'd0, mem[6]}, 32'h0000_00BE);
    chk("byte7", {24'd0, mem[7]}, 32'h0000_00EF);
    step(1'b1, 1'b0, 6'h04, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b1, 1'b0, "raw");
    chk("raw_word", {24'd0, mem[4]}, 32'h0000_00DE);

    // Locked host burst against a continuously requesting CPU: H,H,H,H,C.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0, 6'h0C, 32'h0, 1'b1,
           PRIO ? 1'b1 : (i % 5 == 4), PRIO ? 1'b0 : (i % 5 != 4), "lock_cpu");
    end

    // Locked host alone for 8 cycles; the saturated count yields to the CPU.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0, 6'h14, 32'h0, 1'b1,
           1'b0, 1'b1, "lock_solo");
    end
    step(1'b1, 1'b0, 6'h18, 32'h0, 1'b1, 1'b0, 6'h14, 32'h0, 1'b1, 1'b1, 1'b0, "lock_sat");
    idle("lock_drain");

    // Misaligned host read at 0x0A is served from 0x08.
    step(1'b0, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0, 6'h0A, 32'h0, 1'b0, 1'b0, 1'b1, "misalign");
    idle("misalign_drain");

    // Reset while locked with a read in flight.
    step(1'b0, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0, 6'h10, 32'h0, 1'b1, 1'b0, 1'b1, "pre_rst");
    reset = 1'b1;
    step(1'b1, 1'b0, 6'h20, 32'h0, 1'b0, 1'b0, 6'h00, 32'h0, 1'b0, 1'b1, 1'b0, "in_rst");
    reset = 1'b0;
    step(1'b1, 1'b0, 6'h24, 32'h0, 1'b1, 1'b0, 6'h28, 32'h0, 1'b0, 1'b1, 1'b0, "post_rst_c");
    step(1'b0, 1'b0, 6'h00, 32'h0, 1'b1, 1'b0, 6'h28, 32'h0, 1'b0, 1'b0, 1'b1, "post_rst_h");
    idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
